// File: rtl/rng_extract_pkg.sv
// Shared types and helpers for the range extractor: FSM state encoding and
// bus-width helpers for the element and descriptor payloads.
package rng_extract_pkg;

    localparam int unsigned W_DATA_DEF = 16;
    localparam int unsigned W_CNT_DEF  = 16;

    typedef enum logic [1:0] {
        ST_FIRST  = 2'd0,
        ST_SECOND = 2'd1,
        ST_REST   = 2'd2
    } state_t;

    // Packed widths of {eot, data} and {arith, incr, cnt, base}.
    function automatic int unsigned elem_width(input int unsigned w_data);
        return w_data + 1;
    endfunction

    function automatic int unsigned desc_width(input int unsigned w_data, input int unsigned w_cnt);
        return 2 * w_data + w_cnt + 1;
    endfunction

endpackage

// File: rtl/dti.sv
// Valid/ready data-transfer interface; a beat moves when valid & ready.
interface dti #(
    parameter int unsigned W = 8
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport producer (output valid, output data, input ready);
    modport consumer (input valid, input data, output ready);
endinterface

// File: rtl/rng_extract.sv
// Compresses one eot-terminated element stream into a single
// {arith, incr, cnt, base} descriptor held in a registered output slot.
module rng_extract
    import rng_extract_pkg::*;
#(
    parameter int unsigned W_DATA = W_DATA_DEF,
    parameter int unsigned W_CNT  = W_CNT_DEF
) (
    input logic  clk,
    input logic  rst,
    dti.consumer din,
    dti.producer dout
);

    typedef struct packed {
        logic              eot;
        logic [W_DATA-1:0] data;
    } elem_t;

    typedef struct packed {
        logic              arith;
        logic [W_DATA-1:0] incr;
        logic [W_CNT-1:0]  cnt;
        logic [W_DATA-1:0] base;
    } desc_t;

    if ($bits(din.data) != elem_width(W_DATA)) begin : g_din_width_chk
        $fatal(1, "rng_extract: din width does not match W_DATA+1");
    end
    if ($bits(dout.data) != desc_width(W_DATA, W_CNT)) begin : g_dout_width_chk
        $fatal(1, "rng_extract: dout width does not match 2*W_DATA+W_CNT+1");
    end

    state_t            state;
    logic [W_DATA-1:0] base;
    logic [W_DATA-1:0] incr;
    logic [W_DATA-1:0] prev;
    logic [W_CNT-1:0]  cnt;
    logic              arith;
    logic              out_valid;
    desc_t             out_desc;

    elem_t             beat_c;
    logic              take_c;
    logic [W_DATA-1:0] diff_c;
    logic [W_CNT-1:0]  cnt_inc_c;
    logic              arith_rest_c;

    assign beat_c       = elem_t'(din.data);
    assign din.ready    = !out_valid || dout.ready;
    assign take_c       = din.valid && din.ready;
    assign diff_c       = beat_c.data - prev;
    assign cnt_inc_c    = cnt + W_CNT'(1);
    assign arith_rest_c = arith && (diff_c == incr);

    assign dout.valid = out_valid;
    assign dout.data  = out_desc;

    // Accumulator FSM and output slot; an eot beat reloads the slot in the
    // same cycle the previous result drains, so valid stays high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_FIRST;
            base      <= '0;
            incr      <= '0;
            prev      <= '0;
            cnt       <= '0;
            arith     <= 1'b1;
            out_valid <= 1'b0;
            out_desc  <= '0;
        end else begin
            if (out_valid && dout.ready) begin
                out_valid <= 1'b0;
            end
            if (take_c) begin
                prev <= beat_c.data;
                case (state)
                    ST_FIRST: begin
                        base  <= beat_c.data;
                        cnt   <= W_CNT'(1);
                        incr  <= '0;
                        arith <= 1'b1;
                        if (beat_c.eot) begin
                            state     <= ST_FIRST;
                            out_valid <= 1'b1;
                            out_desc  <= '{arith: 1'b1, incr: '0, cnt: W_CNT'(1), base: beat_c.data};
                        end else begin
                            state <= ST_SECOND;
                        end
                    end
                    ST_SECOND: begin
                        incr <= diff_c;
                        cnt  <= W_CNT'(2);
                        if (beat_c.eot) begin
                            state     <= ST_FIRST;
                            out_valid <= 1'b1;
                            out_desc  <= '{arith: arith, incr: diff_c, cnt: W_CNT'(2), base: base};
                        end else begin
                            state <= ST_REST;
                        end
                    end
                    ST_REST: begin
                        arith <= arith_rest_c;
                        cnt   <= cnt_inc_c;
                        if (beat_c.eot) begin
                            state     <= ST_FIRST;
                            out_valid <= 1'b1;
                            out_desc  <= '{arith: arith_rest_c, incr: incr, cnt: cnt_inc_c, base: base};
                        end else begin
                            state <= ST_REST;
                        end
                    end
                    default: begin
                        state <= ST_FIRST;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/rng_extract.md
RNG_EXTRACT -- requirements
Module: rng_extract

Interface
REQ-001 The module SHALL have a parameter W_DATA, default 16, giving the width of each input element and of the base and incr result fields.
REQ-002 The module SHALL have a parameter W_CNT, default 16, giving the width of the element-count result field.
REQ-003 The module SHALL have a port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have a port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-005 The module SHALL have a port din, dti.consumer, W_DATA+1 bits, carrying packed {eot, data[W_DATA-1:0]} with eot in the MSB.
REQ-006 The module SHALL have a port dout, dti.producer, 1+W_DATA+W_CNT+W_DATA bits, carrying packed {arith, incr, cnt, base} with arith in the MSB and base in the LSBs.

Function
REQ-007 The module SHALL compress one eot-terminated din sequence into one dout descriptor: base = first element, cnt = element count, incr = second element minus first (0 for a 1-element sequence), arith = 1 iff every consecutive difference equals incr.
REQ-008 A din beat SHALL transfer when din.valid & din.ready; a dout result SHALL transfer when dout.valid & dout.ready.
REQ-009 Accumulation SHALL use states FIRST, SECOND and REST; the reset state SHALL be FIRST.
REQ-010 A FIRST beat SHALL load base=data, prev=data, cnt=1, incr=0, arith=1, and move to SECOND, or stay in FIRST if eot=1.
REQ-011 A SECOND beat SHALL load incr=data-prev, prev=data, cnt=2, and move to REST, or to FIRST if eot=1.
REQ-012 A REST beat SHALL clear arith if data-prev != incr, load prev=data and cnt=cnt+1, and move to FIRST if eot=1.
REQ-013 Differences SHALL be computed modulo 2^W_DATA; cnt SHALL wrap modulo 2^W_CNT.
REQ-014 The result SHALL be registered: dout.valid SHALL rise the cycle after the eot beat transfers, and SHALL remain asserted with stable dout.data until dout.ready.
REQ-015 din.ready SHALL equal !dout.valid | dout.ready, with no combinational path from din.valid to din.ready.
REQ-016 In a cycle where a result transfers and the eot beat of the next sequence also transfers, dout SHALL be reloaded with the new result and dout.valid SHALL stay high.
REQ-017 The first beat of the next sequence SHALL be accepted in the cycle immediately after the previous eot beat, with no bubble.
REQ-018 The module SHALL NOT drop or duplicate input beats.

Reset
REQ-019 While rst is high, dout.valid SHALL be 0, state SHALL be FIRST, and base, incr, cnt, prev and dout.data SHALL all be 0, with arith = 1 (dout.data LSBs/fields 0).
REQ-020 Asserting rst mid-sequence SHALL discard the partial sequence, and no result SHALL be emitted for it.
REQ-021 Asserting rst while dout.valid=1 SHALL discard the pending result.

Structure
REQ-022 The input element struct {eot, data} and the descriptor struct {arith, incr, cnt, base} SHALL be defined as parameterised typedefs in the shared rng package.
REQ-023 The module SHALL be a single module with no sub-module; the state register, accumulators and output register SHALL be inline.
REQ-024 An elaboration-time check SHALL $fatal if the din width != W_DATA+1 or the dout width != 2*W_DATA+W_CNT+1.

Verification
REQ-025 Stimulus: 3,5,7,9 (eot on 9) with dout.ready=1 -> one result {arith=1, incr=2, cnt=4, base=3}, 1 cycle after the eot beat.
REQ-026 Stimulus: a single element 42 with eot -> result {arith=1, incr=0, cnt=1, base=42}.
REQ-027 Stimulus: 10,8,6,5 (eot), W_DATA=16 -> result {arith=0, incr=16'hFFFE, cnt=4, base=10}.
REQ-028 Stimulus: back-to-back sequences [1,2](eot) then [7](eot) with dout.ready held low for 5 cycles -> din.ready=0 while the first result is pending, then results {1,1,2,1} and {1,0,1,7} are delivered in order with no beat loss.
REQ-029 Stimulus: continuous valid sequences of length 1 with dout.ready=1 -> one result per cycle at full throughput, with dout.valid never dropping.
REQ-030 Stimulus: rst pulse after 2 beats of 0,4,8(eot), then 5(eot) -> only the result {1,0,1,5} appears.
